// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the RV32I core.
//   - 2 combinational read ports (rs1/rs2), each with a busy scoreboard bit.
//   - 2 write ports. wr1 has priority over wr0 when both target the same address.
//   - Issue port (iss_en/iss_rd) that marks a destination register busy.
//   - Registered debug read port (dbg_addr -> dbg_data, 1 cycle latency).
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   rs{1,2}_addr/_data/_busy    read address, read data, busy bit
//   wr{0,1}_en/_addr/_data      write enable, write address, write data
//   iss_en, iss_rd              issue enable and destination register
//   dbg_addr, dbg_data          debug read address, registered read data
module regfile_mp #(
    parameter int  XLEN     = 32,
    parameter int  NREG     = 32,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_data,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [XLEN-1:0]           dbg_q, dbg_d;

    // Shared read path for all three read ports: x0 clamp, then wr1 > wr0 bypass.
    function automatic logic [XLEN-1:0] rd_val(
        input logic [AW-1:0]             a,
        input logic [NREG-1:0][XLEN-1:0] regs,
        input logic                      w0e,
        input logic [AW-1:0]             w0a,
        input logic [XLEN-1:0]           w0d,
        input logic                      w1e,
        input logic [AW-1:0]             w1a,
        input logic [XLEN-1:0]           w1d
    );
        logic [XLEN-1:0] v;
        v = regs[a];
        if (BYPASS) begin
            if (w1e && w1a == a)      v = w1d;
            else if (w0e && w0a == a) v = w0d;
        end
        // The clamp comes after the bypass so that x0 reads 0 even while it is being written.
        if (ZERO_REG && a == '0) v = '0;
        return v;
    endfunction

    always_comb begin
        rs1_data = rd_val(rs1_addr, regs_q, wr0_en, wr0_addr, wr0_data,
                          wr1_en, wr1_addr, wr1_data);
        rs2_data = rd_val(rs2_addr, regs_q, wr0_en, wr0_addr, wr0_data,
                          wr1_en, wr1_addr, wr1_data);
        dbg_d    = rd_val(dbg_addr, regs_q, wr0_en, wr0_addr, wr0_data,
                          wr1_en, wr1_addr, wr1_data);
    end

    // Busy bits come straight from the register. Issue and write in the current cycle do not bypass into them.
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];
    assign dbg_data = dbg_q;

    always_comb begin
        regs_d = regs_q;
        if (wr0_en) regs_d[wr0_addr] = wr0_data;
        if (wr1_en) regs_d[wr1_addr] = wr1_data;   // applied second, so wr1 wins
        if (ZERO_REG) regs_d[0] = '0;
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            // A same-cycle issue means a newer producer is still pending, so set overrides clear.
            if (iss_en && iss_rd == AW'(r))
                busy_d[r] = 1'b1;
            else if ((wr0_en && wr0_addr == AW'(r)) || (wr1_en && wr1_addr == AW'(r)))
                busy_d[r] = 1'b0;
        end
        if (ZERO_REG) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
            dbg_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            dbg_q  <= dbg_d;
        end
    end

endmodule
